// File: rtl/pong_pkg.sv
// Shared types and geometry for the Pong frame controller and pixel renderer.
package pong_pkg;

    localparam int H_ACTIVE    = 430;
    localparam int V_ACTIVE    = 768;
    localparam int PADDLE_W    = 8;
    localparam int PADDLE_H    = 96;
    localparam int BALL_SIZE   = 8;
    localparam int P1_X        = 16;
    localparam int P2_X        = 406;
    localparam int PADDLE_STEP = 6;
    localparam int BALL_STEP   = 4;
    localparam int SCORE_MAX   = 9;

    // Start-of-game positions (centred)
    localparam logic [9:0] PADDLE_HOME = 10'((V_ACTIVE - PADDLE_H) / 2);
    localparam logic [9:0] BALL_HOME_X = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_HOME_Y = 10'((V_ACTIVE - BALL_SIZE) / 2);

    // 11-bit forms so sums and differences never wrap before clamping
    localparam logic [10:0] PADDLE_Y_MAX  = 11'(V_ACTIVE - PADDLE_H);
    localparam logic [10:0] BALL_X_MAX    = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] BALL_Y_MAX    = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [10:0] PADDLE_STEP_W = 11'(PADDLE_STEP);
    localparam logic [10:0] BALL_STEP_W   = 11'(BALL_STEP);
    localparam logic [10:0] PADDLE_H_W    = 11'(PADDLE_H);
    localparam logic [10:0] BALL_SIZE_W   = 11'(BALL_SIZE);
    localparam logic [10:0] P1_X_W        = 11'(P1_X);
    localparam logic [10:0] P1_FACE       = 11'(P1_X + PADDLE_W);
    localparam logic [10:0] P2_X_W        = 11'(P2_X);
    localparam logic [10:0] P2_BACK       = 11'(P2_X + PADDLE_W);
    localparam logic [10:0] P2_HIT_X      = 11'(P2_X - BALL_SIZE);
    localparam logic [3:0]  SCORE_MAX_V   = 4'(SCORE_MAX);

    // Direction encodings: one bit per axis
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FRAME = 3'd1,
        S_PADDLE     = 3'd2,
        S_BALL       = 3'd3,
        S_COLLIDE    = 3'd4,
        S_SCORE      = 3'd5,
        S_OVER       = 3'd6
    } state_t;

    // Score increment that saturates at the game-ending value
    function automatic logic [3:0] score_inc(input logic [3:0] s);
        return (s >= SCORE_MAX_V) ? SCORE_MAX_V : s + 4'd1;
    endfunction

endpackage

// File: rtl/pong_paddle_ctrl.sv
// One paddle's vertical position: steps up/down on a one-cycle pulse, clamped
// to the visible area; both or neither button held leaves it where it is.
module pong_paddle_ctrl
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       recenter,
    input  logic       step,
    input  logic       up,
    input  logic       dn,
    output logic [9:0] y
);

    logic [10:0] y_ext;
    logic [9:0]  y_up;
    logic [9:0]  y_dn;

    assign y_ext = {1'b0, y};

    // Clamped candidates for a move in either direction
    always_comb begin
        y_up = '0;
        y_dn = PADDLE_Y_MAX[9:0];
        if (y_ext >= PADDLE_STEP_W) begin
            y_up = 10'(y_ext - PADDLE_STEP_W);
        end
        if (y_ext + PADDLE_STEP_W <= PADDLE_Y_MAX) begin
            y_dn = 10'(y_ext + PADDLE_STEP_W);
        end
    end

    // Position register; recenter has priority over a step
    always_ff @(posedge clk) begin
        if (rst || recenter) begin
            y <= PADDLE_HOME;
        end else if (step && (up ^ dn)) begin
            y <= up ? y_up : y_dn;
        end
    end

endmodule

// File: rtl/pong_frame_controller.sv
// Per-frame Pong scheduler: on each vertical-sync falling edge it runs a
// four-cycle update of paddles, ball, collisions and score, then holds all
// outputs steady for the renderer until the next frame.
//
// state      | meaning
// -----------+------------------------------------------------------
// IDLE       | after reset, waiting for start; outputs at home values
// WAIT_FRAME | game running, waiting for the next frame tick
// PADDLE     | paddles step according to buttons
// BALL       | ball moves one step, bouncing off top/bottom
// COLLIDE    | ball reflects off a paddle it overlaps
// SCORE      | point awarded if ball reached a side wall
// OVER       | a player reached the max score; frozen until start
module pong_frame_controller
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       v_sync,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    output logic [9:0] paddle1_y,
    output logic [9:0] paddle2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over,
    output logic       busy
);

    state_t state;

    logic v_sync_q;
    logic frame_tick;
    logic dir_x;
    logic dir_y;
    logic pad_step;
    logic pad_recenter;

    logic [10:0] bx;
    logic [10:0] by;
    logic [10:0] p1;
    logic [10:0] p2;

    logic [9:0] bx_move;
    logic [9:0] by_move;
    logic       dy_move;

    logic overlap1;
    logic overlap2;
    logic hit1;
    logic hit2;

    logic [3:0] score1_next;
    logic [3:0] score2_next;

    assign frame_tick   = v_sync_q & ~v_sync;
    assign pad_step     = (state == S_PADDLE);
    assign pad_recenter = (state == S_OVER) && start;

    pong_paddle_ctrl u_paddle1 (
        .clk      (clk),
        .rst      (rst),
        .recenter (pad_recenter),
        .step     (pad_step),
        .up       (p1_up),
        .dn       (p1_dn),
        .y        (paddle1_y)
    );

    pong_paddle_ctrl u_paddle2 (
        .clk      (clk),
        .rst      (rst),
        .recenter (pad_recenter),
        .step     (pad_step),
        .up       (p2_up),
        .dn       (p2_dn),
        .y        (paddle2_y)
    );

    assign bx = {1'b0, ball_x};
    assign by = {1'b0, ball_y};
    assign p1 = {1'b0, paddle1_y};
    assign p2 = {1'b0, paddle2_y};

    // Ball step with wall clamping; only a top/bottom wall reverses direction
    always_comb begin
        bx_move = ball_x;
        by_move = ball_y;
        dy_move = dir_y;

        if (dir_x == DIR_LEFT) begin
            bx_move = (bx < BALL_STEP_W) ? '0 : 10'(bx - BALL_STEP_W);
        end else begin
            bx_move = (bx + BALL_STEP_W > BALL_X_MAX) ? BALL_X_MAX[9:0]
                                                      : 10'(bx + BALL_STEP_W);
        end

        if (dir_y == DIR_UP) begin
            if (by < BALL_STEP_W) begin
                by_move = '0;
                dy_move = DIR_DOWN;
            end else begin
                by_move = 10'(by - BALL_STEP_W);
            end
        end else begin
            if (by + BALL_STEP_W >= BALL_Y_MAX) begin
                by_move = BALL_Y_MAX[9:0];
                dy_move = DIR_UP;
            end else begin
                by_move = 10'(by + BALL_STEP_W);
            end
        end
    end

    // A paddle only reflects a ball travelling toward it
    assign overlap1 = (by + BALL_SIZE_W > p1) && (by < p1 + PADDLE_H_W);
    assign overlap2 = (by + BALL_SIZE_W > p2) && (by < p2 + PADDLE_H_W);
    assign hit1     = (dir_x == DIR_LEFT) && (bx <= P1_FACE)
                      && (bx + BALL_SIZE_W > P1_X_W) && overlap1;
    assign hit2     = (dir_x == DIR_RIGHT) && (bx + BALL_SIZE_W >= P2_X_W)
                      && (bx < P2_BACK) && overlap2;

    assign score1_next = score_inc(score1);
    assign score2_next = score_inc(score2);

    // Frame sequencer with registered game state and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            v_sync_q  <= 1'b1;
            ball_x    <= BALL_HOME_X;
            ball_y    <= BALL_HOME_Y;
            dir_x     <= DIR_LEFT;
            dir_y     <= DIR_DOWN;
            score1    <= '0;
            score2    <= '0;
            game_over <= 1'b0;
            busy      <= 1'b0;
        end else begin
            v_sync_q <= v_sync;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_WAIT_FRAME;
                    end
                end
                S_WAIT_FRAME: begin
                    if (frame_tick) begin
                        state <= S_PADDLE;
                        busy  <= 1'b1;
                    end
                end
                S_PADDLE: begin
                    state <= S_BALL;
                end
                S_BALL: begin
                    ball_x <= bx_move;
                    ball_y <= by_move;
                    dir_y  <= dy_move;
                    state  <= S_COLLIDE;
                end
                S_COLLIDE: begin
                    if (hit1) begin
                        ball_x <= P1_FACE[9:0];
                        dir_x  <= DIR_RIGHT;
                    end else if (hit2) begin
                        ball_x <= P2_HIT_X[9:0];
                        dir_x  <= DIR_LEFT;
                    end
                    state <= S_SCORE;
                end
                S_SCORE: begin
                    busy  <= 1'b0;
                    state <= S_WAIT_FRAME;
                    if (bx == '0) begin
                        score2 <= score2_next;
                        ball_x <= BALL_HOME_X;
                        ball_y <= BALL_HOME_Y;
                        dir_x  <= DIR_LEFT;
                        dir_y  <= DIR_DOWN;
                        if (score2_next == SCORE_MAX_V) begin
                            state     <= S_OVER;
                            game_over <= 1'b1;
                        end
                    end else if (bx == BALL_X_MAX) begin
                        score1 <= score1_next;
                        ball_x <= BALL_HOME_X;
                        ball_y <= BALL_HOME_Y;
                        dir_x  <= DIR_RIGHT;
                        dir_y  <= DIR_DOWN;
                        if (score1_next == SCORE_MAX_V) begin
                            state     <= S_OVER;
                            game_over <= 1'b1;
                        end
                    end
                end
                S_OVER: begin
                    if (start) begin
                        score1    <= '0;
                        score2    <= '0;
                        ball_x    <= BALL_HOME_X;
                        ball_y    <= BALL_HOME_Y;
                        dir_x     <= DIR_LEFT;
                        dir_y     <= DIR_DOWN;
                        game_over <= 1'b0;
                        state     <= S_WAIT_FRAME;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_frame_controller.sv
// Bench for pong_frame_controller: directed vectors, corner sequences and
// randomized play compared against a per-frame game model.
module tb_pong_frame_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       v_sync;
    logic       start;
    logic       p1_up, p1_dn, p2_up, p2_dn;
    logic [9:0] paddle1_y, paddle2_y, ball_x, ball_y;
    logic [3:0] score1, score2;
    logic       game_over, busy;

    always #5 clk = ~clk;

    pong_frame_controller dut (
        .clk       (clk),
        .rst       (rst),
        .v_sync    (v_sync),
        .start     (start),
        .p1_up     (p1_up),
        .p1_dn     (p1_dn),
        .p2_up     (p2_up),
        .p2_dn     (p2_dn),
        .paddle1_y (paddle1_y),
        .paddle2_y (paddle2_y),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .score1    (score1),
        .score2    (score2),
        .game_over (game_over),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- game model (one call = one whole frame) ----------------
    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_OVER = 2;

    int m_p1, m_p2, m_bx, m_by, m_dx, m_dy, m_s1, m_s2, m_mode;

    task automatic m_home();
        m_p1 = 336; m_p2 = 336;
        m_bx = 211; m_by = 380;
        m_dx = -1;  m_dy = 1;
    endtask

    task automatic m_reset();
        m_home();
        m_s1 = 0; m_s2 = 0;
        m_mode = M_IDLE;
    endtask

    function automatic int paddle_move(input int y, input logic up, input logic dn);
        if (up && !dn) return (y < 6) ? 0 : y - 6;
        if (dn && !up) return (y + 6 > 672) ? 672 : y + 6;
        return y;
    endfunction

    task automatic m_frame(input logic u1, input logic d1, input logic u2, input logic d2);
        m_p1 = paddle_move(m_p1, u1, d1);
        m_p2 = paddle_move(m_p2, u2, d2);
        m_by = m_by + 4 * m_dy;
        if (m_by < 0) begin
            m_by = 0; m_dy = 1;
        end else if (m_by >= 760) begin
            m_by = 760; m_dy = -1;
        end
        m_bx = m_bx + 4 * m_dx;
        if (m_bx < 0)   m_bx = 0;
        if (m_bx > 422) m_bx = 422;
        if (m_dx < 0 && m_bx <= 24 && m_bx + 8 > 16 && m_by + 8 > m_p1 && m_by < m_p1 + 96) begin
            m_bx = 24; m_dx = 1;
        end else if (m_dx > 0 && m_bx + 8 >= 406 && m_bx < 414 && m_by + 8 > m_p2 && m_by < m_p2 + 96) begin
            m_bx = 398; m_dx = -1;
        end
        if (m_bx == 0) begin
            if (m_s2 < 9) m_s2++;
            m_bx = 211; m_by = 380; m_dx = -1; m_dy = 1;
            if (m_s2 == 9) m_mode = M_OVER;
        end else if (m_bx == 422) begin
            if (m_s1 < 9) m_s1++;
            m_bx = 211; m_by = 380; m_dx = 1; m_dy = 1;
            if (m_s1 == 9) m_mode = M_OVER;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".paddle1_y"}, paddle1_y, m_p1);
        check({tag, ".paddle2_y"}, paddle2_y, m_p2);
        check({tag, ".ball_x"},    ball_x,    m_bx);
        check({tag, ".ball_y"},    ball_y,    m_by);
        check({tag, ".score1"},    score1,    m_s1);
        check({tag, ".score2"},    score2,    m_s2);
        check({tag, ".game_over"}, game_over, (m_mode == M_OVER) ? 1 : 0);
        check({tag, ".busy_idle"}, busy,      0);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (m_mode == M_IDLE) begin
            m_mode = M_PLAY;
        end else if (m_mode == M_OVER) begin
            m_home();
            m_s1 = 0; m_s2 = 0;
            m_mode = M_PLAY;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; v_sync = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    // One v_sync low pulse with buttons held through the update window
    task automatic do_frame(input logic u1, input logic d1, input logic u2, input logic d2,
                            input string tag);
        int first;
        int cnt;
        @(negedge clk);
        p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2;
        repeat ($urandom_range(2, 6)) @(negedge clk);
        v_sync = 1'b0;
        first = -1;
        cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) begin
                cnt++;
                if (first < 0) first = i;
            end
            if (i == 2) v_sync = 1'b1;
        end
        if (m_mode == M_PLAY) begin
            m_frame(u1, d1, u2, d2);
            check({tag, ".busy_len"}, cnt, 4);
            check({tag, ".busy_first"}, first, 1);
        end else begin
            check({tag, ".busy_len"}, cnt, 0);
        end
        check_all(tag);
    endtask

    typedef struct {
        logic u1, d1, u2, d2;
        int   frames;
        int   exp_p1;
        int   exp_p2;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int first;
        int f;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 56, 0,   672};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  0,   672};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1,  0,   672};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 3,  0,   672};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 10, 60,  612};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 2,  60,  612};

        rst = 1'b1; v_sync = 1'b1; start = 1'b0;
        p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all("reset");

        // Frame ticks are ignored before start
        do_frame(0, 0, 0, 0, "idle_tick");

        // First frame of play: ball moves one step left/down, paddles hold
        do_start();
        do_frame(0, 0, 0, 0, "first_frame");
        check("first.ball_x", ball_x, 207);
        check("first.ball_y", ball_y, 384);
        check("first.paddle1_y", paddle1_y, 336);

        // Paddle vectors, including clamping at both ends and both-buttons hold
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < vecs[v].frames; k++) begin
                do_frame(vecs[v].u1, vecs[v].d1, vecs[v].u2, vecs[v].d2, $sformatf("vec%0d", v));
            end
            check($sformatf("vec%0d.p1", v), paddle1_y, vecs[v].exp_p1);
            check($sformatf("vec%0d.p2", v), paddle2_y, vecs[v].exp_p2);
        end

        // Undefended left side: right player scores to the maximum
        do_reset();
        do_start();
        f = 0;
        while (f < 600 && !game_over) begin
            do_frame(0, 0, 0, 0, "to_over");
            f++;
        end
        check("over.game_over", game_over, 1);
        check("over.score2", score2, 9);
        check("over.score1", score1, 0);
        do_frame(0, 0, 0, 0, "over_frozen");
        do_frame(1, 0, 0, 1, "over_frozen_btn");
        do_start();
        check_all("restart");
        check("restart.score2", score2, 0);
        check("restart.game_over", game_over, 0);

        // Reset asserted while the update sits in BALL
        @(negedge clk);
        p1_up = 1'b1;
        v_sync = 1'b0;
        first = 0;
        for (int i = 0; i < 6 && !busy; i++) begin
            @(posedge clk);
            @(negedge clk);
            v_sync = 1'b1;
            first++;
        end
        check("midreset.busy_seen", busy, 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        p1_up = 1'b0;
        m_reset();
        check_all("midreset");

        // Randomized play against the model
        do_start();
        for (int n = 0; n < 500; n++) begin
            logic [3:0] btn;
            btn = 4'($urandom_range(0, 15));
            if (m_mode == M_OVER && $urandom_range(0, 1) == 1) do_start();
            else if ($urandom_range(0, 15) == 0) do_start();
            do_frame(btn[3], btn[2], btn[1], btn[0], "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
